// File: rtl/data_distributor_if.sv
// Stream bus between the distributor and its source/consumers.
// One input valid/ready stream, NOUT output channels and the round-robin pointer status.
interface data_distributor_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NOUT  = 4
);
    localparam int unsigned SELW = $clog2(NOUT);

    logic [1:0]            MODE;
    logic [SELW-1:0]       SEL;
    logic [WIDTH-1:0]      IN_DATA;
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [NOUT*WIDTH-1:0] OUT_DATA;
    logic [NOUT-1:0]       OUT_VALID;
    logic [NOUT-1:0]       OUT_READY;
    logic [SELW-1:0]       RR_PTR;

    modport master (
        output MODE, SEL, IN_DATA, IN_VALID, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_VALID, RR_PTR
    );

    modport slave (
        input  MODE, SEL, IN_DATA, IN_VALID, OUT_READY,
        output IN_READY, OUT_DATA, OUT_VALID, RR_PTR
    );
endinterface

// File: rtl/data_distributor.sv
// 1-to-NOUT stream distributor: each input word goes to one channel (select or
// round-robin) or to all channels (broadcast). Every channel keeps a single holding register.
module data_distributor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NOUT  = 4
) (
    input logic              CLK,
    input logic              RST,
    data_distributor_if.slave bus
);
    localparam int unsigned SELW = $clog2(NOUT);

    localparam logic [1:0] MODE_SEL   = 2'b00;
    localparam logic [1:0] MODE_RR    = 2'b01;
    localparam logic [1:0] MODE_BCAST = 2'b10;

    logic [NOUT-1:0]       valid_q, valid_d;
    logic [NOUT*WIDTH-1:0] data_q,  data_d;
    logic [SELW-1:0]       ptr_q,   ptr_d;

    logic [NOUT-1:0]       free_c;
    logic [NOUT-1:0]       target_c;
    logic [NOUT-1:0]       load_c;
    logic                  in_ready_c;
    logic                  accept_c;

    // Target set, readiness and next state; IN_VALID only gates the load, never IN_READY.
    always_comb begin
        free_c     = ~valid_q | bus.OUT_READY;
        target_c   = '0;
        in_ready_c = 1'b0;
        accept_c   = 1'b0;
        load_c     = '0;
        valid_d    = valid_q;
        data_d     = data_q;
        ptr_d      = ptr_q;

        case (bus.MODE)
            MODE_SEL:   target_c[bus.SEL] = 1'b1;
            MODE_RR:    target_c[ptr_q]   = 1'b1;
            MODE_BCAST: target_c          = '1;
            default:    target_c          = '0;
        endcase

        // Broadcast needs every channel free at once; no partial delivery.
        in_ready_c = (target_c != '0) && ((target_c & ~free_c) == '0);
        accept_c   = in_ready_c && bus.IN_VALID;
        load_c     = accept_c ? target_c : '0;

        // A drain and a reload in the same cycle leave the channel valid with new data.
        valid_d = (valid_q & ~bus.OUT_READY) | load_c;
        for (int k = 0; k < int'(NOUT); k++) begin
            if (load_c[k]) begin
                data_d[k*WIDTH +: WIDTH] = bus.IN_DATA;
            end
        end

        // Power-of-two NOUT makes the pointer wrap naturally.
        if (accept_c && (bus.MODE == MODE_RR)) begin
            ptr_d = ptr_q + SELW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.IN_READY  = in_ready_c;
    assign bus.OUT_VALID = valid_q;
    assign bus.OUT_DATA  = data_q;
    assign bus.RR_PTR    = ptr_q;
endmodule

// File: tb/tb_data_distributor.sv
// Table-driven bench for data_distributor (WIDTH=8, NOUT=4) with a queue of
// expected post-edge results, plus a bounded broadcast-stall sequence.
module tb_data_distributor;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NOUT  = 4;

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic        vld;
        logic [7:0]  din;
        logic [3:0]  ordy;
        logic        x_rdy;
        logic [3:0]  x_ov;
        logic [31:0] x_od;
        logic [1:0]  x_ptr;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  ov;
        logic [31:0] od;
        logic [1:0]  ptr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    exp_t sbq[$];

    always #5 clk = ~clk;

    data_distributor_if #(.WIDTH(WIDTH), .NOUT(NOUT)) bus ();

    data_distributor #(.WIDTH(WIDTH), .NOUT(NOUT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic r, input logic [1:0] m, input logic [1:0] s,
                       input logic v, input logic [7:0] d, input logic [3:0] o,
                       input logic xr, input logic [3:0] xov, input logic [31:0] xod,
                       input logic [1:0] xp);
        vec_t t;
        t.name = name; t.rst = r; t.mode = m; t.sel = s; t.vld = v; t.din = d; t.ordy = o;
        t.x_rdy = xr; t.x_ov = xov; t.x_od = xod; t.x_ptr = xp;
        vecs.push_back(t);
    endtask

    initial begin
        exp_t e;
        int   acc;

        rst           = 1'b1;
        bus.MODE      = 2'b00;
        bus.SEL       = '0;
        bus.IN_DATA   = '0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = '0;

        // name, rst, mode, sel, vld, din, ordy, exp_rdy, exp_ov, exp_od, exp_ptr
        add("sel_s1",   0, 2'b00, 2'd2, 1, 8'h11, 4'hF, 1, 4'b0100, 32'h0011_0000, 2'd0);
        add("sel_s2",   0, 2'b00, 2'd2, 1, 8'h22, 4'hF, 1, 4'b0100, 32'h0022_0000, 2'd0);
        add("sel_s3",   0, 2'b00, 2'd2, 1, 8'h33, 4'hF, 1, 4'b0100, 32'h0033_0000, 2'd0);
        add("sel_idle", 0, 2'b00, 2'd2, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h0033_0000, 2'd0);
        add("bp_a5",    0, 2'b00, 2'd1, 1, 8'hA5, 4'hD, 1, 4'b0010, 32'h0033_A500, 2'd0);
        add("bp_wait1", 0, 2'b00, 2'd1, 1, 8'h5A, 4'hD, 0, 4'b0010, 32'h0033_A500, 2'd0);
        add("bp_wait2", 0, 2'b00, 2'd1, 1, 8'h5A, 4'hD, 0, 4'b0010, 32'h0033_A500, 2'd0);
        add("bp_rel",   0, 2'b00, 2'd1, 1, 8'h5A, 4'hF, 1, 4'b0010, 32'h0033_5A00, 2'd0);
        add("bp_drain", 0, 2'b00, 2'd1, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h0033_5A00, 2'd0);
        add("rr_w0",    0, 2'b01, 2'd0, 1, 8'h00, 4'hF, 1, 4'b0001, 32'h0033_5A00, 2'd1);
        add("rr_w1",    0, 2'b01, 2'd0, 1, 8'h01, 4'hF, 1, 4'b0010, 32'h0033_0100, 2'd2);
        add("rr_w2",    0, 2'b01, 2'd0, 1, 8'h02, 4'hF, 1, 4'b0100, 32'h0002_0100, 2'd3);
        add("rr_w3",    0, 2'b01, 2'd0, 1, 8'h03, 4'hF, 1, 4'b1000, 32'h0302_0100, 2'd0);
        add("rr_w4",    0, 2'b01, 2'd0, 1, 8'h04, 4'hF, 1, 4'b0001, 32'h0302_0104, 2'd1);
        add("rr_w5",    0, 2'b01, 2'd0, 1, 8'h05, 4'hF, 1, 4'b0010, 32'h0302_0504, 2'd2);
        add("rr_hold",  0, 2'b00, 2'd0, 1, 8'h77, 4'hF, 1, 4'b0001, 32'h0302_0577, 2'd2);
        add("rr_idle",  0, 2'b01, 2'd0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h0302_0577, 2'd2);
        add("bc_fill3", 0, 2'b00, 2'd3, 1, 8'h99, 4'h7, 1, 4'b1000, 32'h9902_0577, 2'd2);
        add("bc_stall1",0, 2'b10, 2'd0, 1, 8'hC3, 4'h7, 0, 4'b1000, 32'h9902_0577, 2'd2);
        add("bc_stall2",0, 2'b10, 2'd0, 1, 8'hC3, 4'h7, 0, 4'b1000, 32'h9902_0577, 2'd2);
        add("bc_rel",   0, 2'b10, 2'd0, 1, 8'hC3, 4'hF, 1, 4'b1111, 32'hC3C3_C3C3, 2'd2);
        add("bc_drain", 0, 2'b10, 2'd0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'hC3C3_C3C3, 2'd2);
        add("res_empty",0, 2'b11, 2'd0, 1, 8'h55, 4'hF, 0, 4'b0000, 32'hC3C3_C3C3, 2'd2);
        add("res_fill", 0, 2'b10, 2'd0, 1, 8'h3C, 4'h0, 1, 4'b1111, 32'h3C3C_3C3C, 2'd2);
        add("res_full", 0, 2'b11, 2'd0, 1, 8'h55, 4'h0, 0, 4'b1111, 32'h3C3C_3C3C, 2'd2);
        add("res_drain",0, 2'b11, 2'd0, 1, 8'h55, 4'h5, 0, 4'b1010, 32'h3C3C_3C3C, 2'd2);
        add("rst_full", 1, 2'b01, 2'd0, 1, 8'hAA, 4'h0, 1, 4'b0000, 32'h0000_0000, 2'd0);
        add("rst_after",0, 2'b01, 2'd0, 0, 8'h00, 4'h0, 1, 4'b0000, 32'h0000_0000, 2'd0);
        add("rt_fill0", 0, 2'b00, 2'd0, 1, 8'h12, 4'h0, 1, 4'b0001, 32'h0000_0012, 2'd0);
        add("rt_wait",  0, 2'b00, 2'd0, 1, 8'h34, 4'h0, 0, 4'b0001, 32'h0000_0012, 2'd0);
        add("rt_resel", 0, 2'b00, 2'd1, 1, 8'h34, 4'h0, 1, 4'b0011, 32'h0000_3412, 2'd0);
        add("rr_block", 0, 2'b01, 2'd0, 1, 8'h56, 4'h0, 0, 4'b0011, 32'h0000_3412, 2'd0);
        add("rr_reload",0, 2'b01, 2'd0, 1, 8'h56, 4'h1, 1, 4'b0011, 32'h0000_3456, 2'd1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ov",  32'(bus.OUT_VALID), 32'h0);
        chk("reset_od",  32'(bus.OUT_DATA),  32'h0);
        chk("reset_ptr", 32'(bus.RR_PTR),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_rdy", 32'(bus.IN_READY), 32'h1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.MODE      = vecs[i].mode;
            bus.SEL       = vecs[i].sel;
            bus.IN_VALID  = vecs[i].vld;
            bus.IN_DATA   = vecs[i].din;
            bus.OUT_READY = vecs[i].ordy;
            #1;
            chk($sformatf("%s/rdy", vecs[i].name), 32'(bus.IN_READY), 32'(vecs[i].x_rdy));
            sbq.push_back('{name: vecs[i].name, ov: vecs[i].x_ov, od: vecs[i].x_od, ptr: vecs[i].x_ptr});
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("%s/ov",  e.name), 32'(bus.OUT_VALID), 32'(e.ov));
            chk($sformatf("%s/od",  e.name), 32'(bus.OUT_DATA),  e.od);
            chk($sformatf("%s/ptr", e.name), 32'(bus.RR_PTR),    32'(e.ptr));
        end

        // Broadcast waits for all channels; consumers stall three cycles, then release together.
        rst          = 1'b0;
        bus.MODE     = 2'b10;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 8'hBB;
        acc          = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.OUT_READY = (c < 3) ? 4'h0 : 4'hF;
            #1;
            if (bus.IN_READY) begin
                acc = c;
                break;
            end
        end
        chk("bc_wait_cycle", 32'(acc), 32'd3);
        @(posedge clk);
        #1;
        chk("bc_wait_ov", 32'(bus.OUT_VALID), 32'hF);
        chk("bc_wait_od", 32'(bus.OUT_DATA),  32'hBBBB_BBBB);
        chk("bc_wait_ptr", 32'(bus.RR_PTR),   32'h1);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        @(posedge clk);
        #1;
        chk("bc_final_drain", 32'(bus.OUT_VALID), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/data_distributor.md
# data_distributor

Clocked 1-to-NOUT stream distributor: accepts words on a single valid/ready input and delivers each word to one output channel, or to all channels. The destination is chosen by an external select, an internal round-robin pointer, or broadcast. Each output channel owns a one-word holding register. The block is the sending-side counterpart of the 2:1 data selector: it fans one stream out to several consumers on the LogiPi fabric, where the selector merges sources into one.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.
- NOUT, 4, number of output channels; power of two, 2 to 16.
- SELW, $clog2(NOUT), width of SEL and of the round-robin pointer; derived, do not override.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- MODE  input  2  00 select, 01 round-robin, 10 broadcast, 11 reserved.
- SEL  input  SELW  destination channel in select mode.
- IN_DATA  input  WIDTH  input word.
- IN_VALID  input  1  input word present.
- IN_READY  output  1  block can accept the input word this cycle.
- OUT_DATA  output  NOUT*WIDTH  channel k data is bits [k*WIDTH +: WIDTH].
- OUT_VALID  output  NOUT  channel k holds a word.
- OUT_READY  input  NOUT  consumer k takes its word this cycle.
- RR_PTR  output  SELW  current round-robin pointer (status).

## Operation
- Channel k is free when OUT_VALID[k]=0 or OUT_READY[k]=1.
- Target set T:
  - Select mode: {SEL}.
  - Round-robin mode: {RR_PTR}.
  - Broadcast mode: all channels.
  - Reserved mode: empty.
- IN_READY is 1 only when T is non-empty and every channel in T is free. It is combinational from MODE, SEL, RR_PTR, OUT_VALID and OUT_READY, and never depends on IN_VALID.
- An accept occurs when IN_VALID and IN_READY are both 1. On accept, every channel in T loads IN_DATA and sets OUT_VALID.
- Channel k drains when OUT_VALID[k] and OUT_READY[k] are both 1. OUT_VALID[k] then clears, unless the same cycle's accept reloads channel k, in which case it stays 1 with the new data.
- Round-robin pointer:
  - Advances by 1 only on an accept in round-robin mode.
  - Wraps from NOUT-1 to 0.
  - Holds its value in every other mode, so a mode change does not clear it.
- Channels not in T are unaffected by an accept. OUT_DATA[k] holds its last value while OUT_VALID[k] is 0.
- Reserved mode: nothing is accepted and the pointer holds; held words still drain normally.
- MODE and SEL are sampled in the accept cycle only. Changing them while IN_VALID=1 and IN_READY=0 is legal and retargets the pending word.

## Timing
- Reset (RST=1 at an edge): OUT_VALID=0, OUT_DATA=0, RR_PTR=0. IN_READY follows combinationally, so it is 1 in modes 00, 01 and 10 after reset. Words held at reset are discarded. Reset has priority over accept and drain in the same edge.
- Latency: a word accepted at edge n appears with OUT_VALID=1 after edge n.
- Throughput: one word per cycle into a channel whose consumer holds OUT_READY=1 continuously (simultaneous drain and reload). In round-robin mode, one word per cycle whenever successive targets are free.
- Broadcast stalls until all NOUT channels are free simultaneously; there is no partial delivery.
- No combinational path from IN_VALID or IN_DATA to any output.

## Test plan
- Select streaming: reset, MODE=00, SEL=2, send 0x11/0x22/0x33 back-to-back with OUT_READY=1111 -> OUT_VALID=0100 and channel 2 data 0x11, 0x22, 0x33 on consecutive cycles, IN_READY constantly 1, other channels never valid.
- Backpressure: MODE=00, SEL=1, OUT_READY[1]=0, send 0xA5 then 0x5A -> 0xA5 held, IN_READY=0 while 0x5A waits. Raise OUT_READY[1] for one cycle -> 0x5A accepted that cycle, channel 1 shows 0x5A next cycle.
- Round-robin wrap: MODE=01, NOUT=4, OUT_READY=1111, send 6 words 0..5 -> channels 0,1,2,3,0,1 receive them; RR_PTR ends at 2. Then switch to MODE=00, send one word -> RR_PTR stays 2.
- Broadcast: MODE=10 with channel 3 full and OUT_READY[3]=0, send 0xC3 -> IN_READY=0. Release channel 3 -> 0xC3 is loaded into all four channels in one edge and OUT_VALID=1111.
- Reserved mode and reset: MODE=11, IN_VALID=1 -> IN_READY=0, no accept, RR_PTR unchanged. Assert RST with channels full -> all OUT_VALID=0, OUT_DATA=0 and RR_PTR=0 after that edge, even with IN_VALID=1 in that cycle.
